// File: rtl/inst_loader_mem.sv
// rtl/inst_loader_mem.sv - instruction memory with a byte-serial loader and a registered fetch port.
// Optional build macro INST_MEM_CHECKSUM_EN adds the load_checksum output.
module inst_loader_mem #(
  parameter int ADDR_WIDTH     = 10,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                          CLK,
  input  logic                          reset_n,
  input  logic [ADDR_WIDTH-1:0]         pc,
  output logic [8*BYTES_PER_WORD-1:0]   inst,
  input  logic                          loader_enable,
  input  logic                          loader_ready,
  input  logic [7:0]                    loader_data,
  output logic                          loader_busy,
  output logic                          load_done,
  output logic [ADDR_WIDTH:0]           load_count,
  output logic                          load_overflow
`ifdef INST_MEM_CHECKSUM_EN
  ,
  output logic [8*BYTES_PER_WORD-1:0]   load_checksum
`endif
);

  localparam int W     = 8 * BYTES_PER_WORD;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [CW-1:0]    LAST_SLOT = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, FULL} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [W-1:0]            mem [DEPTH];
  logic [W-1:0]            word;
  logic [IDX_W-1:0]        idx;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic                    last_slot;
  logic                    start;
  logic                    lane_we;
  logic                    commit_we;
  logic                    done_set;
  logic                    ovf_set;

  assign last_slot = (load_count == LAST_SLOT);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (loader_enable) state_next = COLLECT;
      end
      COLLECT: begin
        if (!loader_enable) state_next = IDLE;
        else if (loader_ready && idx == LAST_IDX) state_next = COMMIT;
      end
      COMMIT: begin
        if (!loader_enable) state_next = IDLE;
        else if (last_slot) state_next = FULL;
        else state_next = COLLECT;
      end
      FULL: begin
        if (!loader_enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A byte arriving in the COMMIT cycle becomes lane 0 of the next word, unless memory just filled.
  always_comb begin
    loader_busy = (state != IDLE);
    start       = (state == IDLE) && loader_enable;
    commit_we   = (state == COMMIT);
    lane_we     = loader_enable && loader_ready &&
                  ((state == COLLECT) || ((state == COMMIT) && !last_slot));
    ovf_set     = loader_ready &&
                  ((state == FULL) || ((state == COMMIT) && last_slot && loader_enable));
    done_set    = !loader_enable && !load_overflow &&
                  ((state == FULL) || (state == COMMIT) ||
                   ((state == COLLECT) && (idx == '0)));
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      idx           <= '0;
      waddr         <= '0;
      word          <= '0;
      load_count    <= '0;
      load_overflow <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      load_done <= done_set;
      if (start) begin
        idx           <= '0;
        waddr         <= '0;
        load_count    <= '0;
        load_overflow <= 1'b0;
      end
      if (commit_we) begin
        load_count <= load_count + CW'(1);
        idx        <= '0;
        // Hold the address on the final slot so it never wraps back onto word 0.
        if (!last_slot) waddr <= waddr + ADDR_WIDTH'(1);
      end
      if (lane_we) begin
        word[idx*8 +: 8] <= loader_data;
        idx              <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      if (ovf_set) load_overflow <= 1'b1;
    end
  end

`ifdef INST_MEM_CHECKSUM_EN
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      load_checksum <= '0;
    end else if (start) begin
      load_checksum <= '0;
    end else if (commit_we) begin
      load_checksum <= load_checksum ^ word;
    end
  end
`else
`endif

  // Memory is deliberately left out of reset so committed words survive an interrupted session.
  always_ff @(posedge CLK) begin
    if (commit_we) mem[waddr] <= word;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      inst <= '0;
    end else begin
      inst <= mem[pc];
    end
  end

endmodule
